// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: shared types and default constants for the qeciphy RX path.
package qeciphy_pkg;

   typedef enum logic [2:0] {
      WAIT_GT,
      SETTLE,
      ALIGN,
      LINKED,
      GT_RESET,
      FAILED
   } rx_align_ctrl_fsm_t;

   localparam int RX_ALIGN_SETTLE_CYCLES        = 64;
   localparam int RX_ALIGN_ALIGN_TIMEOUT_CYCLES = 65536;
   localparam int RX_ALIGN_FAILS_PER_RESET      = 4;
   localparam int RX_ALIGN_GT_RESET_CYCLES      = 16;
   localparam int RX_ALIGN_MAX_RETRIES          = 3;

endpackage

// File: rtl/qeciphy_sat_counter.sv
// qeciphy_sat_counter: saturating up-counter with clear, enable and terminal-count flag.
module qeciphy_sat_counter #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr ? '0 : (en && cnt_q != MAX_V) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

   assign tc = cnt_q == MAX_V;

endmodule

// File: rtl/qeciphy_rx_align_ctrl.sv
// qeciphy_rx_align_ctrl: sequences aligner reset release, watches alignment
// outcome and escalates failures/timeouts into transceiver RX resets.
module qeciphy_rx_align_ctrl
   import qeciphy_pkg::*;
#(
   parameter int SETTLE_CYCLES        = RX_ALIGN_SETTLE_CYCLES,
   parameter int ALIGN_TIMEOUT_CYCLES = RX_ALIGN_ALIGN_TIMEOUT_CYCLES,
   parameter int FAILS_PER_RESET      = RX_ALIGN_FAILS_PER_RESET,
   parameter int GT_RESET_CYCLES      = RX_ALIGN_GT_RESET_CYCLES,
   parameter int MAX_RETRIES          = RX_ALIGN_MAX_RETRIES,
   localparam int RW                  = $clog2(MAX_RETRIES + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_gt_rx_rdy,
   input  logic          i_align_done,
   input  logic          i_align_fail,
   input  logic          i_link_lost,
   input  logic          i_restart,
   output logic          o_aligner_rst_n,
   output logic          o_gt_rx_reset,
   output logic          o_link_up,
   output logic          o_link_fail,
   output logic [RW-1:0] o_retry_count
);

   localparam logic [RW-1:0] MAX_RETRIES_V = RW'(MAX_RETRIES);

   rx_align_ctrl_fsm_t state_q, state_d;
   logic [RW-1:0]      retry_q, retry_d;
   logic               settle_tc, timeout_tc, fail_tc, gt_tc;
   logic               fail_hit;

   qeciphy_sat_counter #(.WIDTH($clog2(SETTLE_CYCLES + 1)), .MAX(SETTLE_CYCLES - 1)) u_settle_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != SETTLE), .en(state_q == SETTLE), .tc(settle_tc)
   );

   qeciphy_sat_counter #(.WIDTH($clog2(ALIGN_TIMEOUT_CYCLES)), .MAX(ALIGN_TIMEOUT_CYCLES - 1)) u_timeout_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != ALIGN), .en(state_q == ALIGN), .tc(timeout_tc)
   );

   // tc marks FAILS_PER_RESET-1 pulses seen, so the next counted pulse escalates
   qeciphy_sat_counter #(.WIDTH($clog2(FAILS_PER_RESET + 1)), .MAX(FAILS_PER_RESET - 1)) u_fail_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != ALIGN), .en(state_q == ALIGN && i_align_fail), .tc(fail_tc)
   );

   qeciphy_sat_counter #(.WIDTH($clog2(GT_RESET_CYCLES + 1)), .MAX(GT_RESET_CYCLES - 1)) u_gt_cnt (
      .clk(clk), .rst_n(rst_n), .clr(state_q != GT_RESET), .en(state_q == GT_RESET), .tc(gt_tc)
   );

   assign fail_hit = i_align_fail && fail_tc;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      case (state_q)
         WAIT_GT:  if (i_gt_rx_rdy) state_d = SETTLE;
         SETTLE:   state_d = !i_gt_rx_rdy ? WAIT_GT : settle_tc ? ALIGN : SETTLE;
         ALIGN: begin
            if (!i_gt_rx_rdy) state_d = WAIT_GT;
            else if (i_align_done) begin
               state_d = LINKED;
               retry_d = '0;
            end else if (fail_hit || timeout_tc) begin
               state_d = (retry_q == MAX_RETRIES_V) ? FAILED : GT_RESET;
               retry_d = (retry_q == MAX_RETRIES_V) ? retry_q : retry_q + 1'b1;
            end
         end
         LINKED:   state_d = !i_gt_rx_rdy ? WAIT_GT : (i_link_lost || !i_align_done) ? SETTLE : LINKED;
         GT_RESET: if (gt_tc) state_d = WAIT_GT;
         FAILED: begin
            if (i_restart) begin
               state_d = WAIT_GT;
               retry_d = '0;
            end
         end
         default:  state_d = WAIT_GT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q         <= WAIT_GT;
         retry_q         <= '0;
         o_aligner_rst_n <= 1'b0;
         o_gt_rx_reset   <= 1'b0;
         o_link_up       <= 1'b0;
         o_link_fail     <= 1'b0;
         o_retry_count   <= '0;
      end else begin
         state_q         <= state_d;
         retry_q         <= retry_d;
         o_aligner_rst_n <= state_q == ALIGN || state_q == LINKED;
         o_gt_rx_reset   <= state_q == GT_RESET;
         o_link_up       <= state_q == LINKED;
         o_link_fail     <= state_q == FAILED;
         o_retry_count   <= retry_q;
      end

endmodule

// File: tb/tb_qeciphy_rx_align_ctrl.sv
// tb_qeciphy_rx_align_ctrl: directed bench for the RX alignment sequencer using
// small parameters; cycle numbers count edges after the stimulus start.
module tb_qeciphy_rx_align_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_gt_rx_rdy = 1'b0;
   logic       i_align_done = 1'b0;
   logic       i_align_fail = 1'b0;
   logic       i_link_lost = 1'b0;
   logic       i_restart = 1'b0;
   logic       o_aligner_rst_n, o_gt_rx_reset, o_link_up, o_link_fail;
   logic [1:0] o_retry_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   qeciphy_rx_align_ctrl #(
      .SETTLE_CYCLES(8), .ALIGN_TIMEOUT_CYCLES(100), .FAILS_PER_RESET(2),
      .GT_RESET_CYCLES(4), .MAX_RETRIES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_gt_rx_rdy(i_gt_rx_rdy), .i_align_done(i_align_done),
      .i_align_fail(i_align_fail), .i_link_lost(i_link_lost), .i_restart(i_restart),
      .o_aligner_rst_n(o_aligner_rst_n), .o_gt_rx_reset(o_gt_rx_reset), .o_link_up(o_link_up),
      .o_link_fail(o_link_fail), .o_retry_count(o_retry_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic check_all(input string tag, input logic al, gt, up, fl, input logic [1:0] rc);
      check({tag, ".aligner_rst_n"}, 32'(o_aligner_rst_n), 32'(al));
      check({tag, ".gt_rx_reset"}, 32'(o_gt_rx_reset), 32'(gt));
      check({tag, ".link_up"}, 32'(o_link_up), 32'(up));
      check({tag, ".link_fail"}, 32'(o_link_fail), 32'(fl));
      check({tag, ".retry"}, 32'(o_retry_count), 32'(rc));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {i_gt_rx_rdy, i_align_done, i_align_fail, i_link_lost, i_restart} = '0;
      tick();
      tick();
      check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      // Nominal bring-up, then link loss
      do_reset();
      i_gt_rx_rdy = 1'b1;
      go_to(9);  check("nom.rel_early", 32'(o_aligner_rst_n), 32'd0);
      go_to(10); check("nom.rel", 32'(o_aligner_rst_n), 32'd1);
      go_to(20); i_align_done = 1'b1;
      go_to(21); check("nom.up_early", 32'(o_link_up), 32'd0);
      go_to(22); check_all("nom.linked", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      go_to(30); i_link_lost = 1'b1;
      go_to(31); i_link_lost = 1'b0;
      go_to(32); check_all("loss.settle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      go_to(39); check_all("loss.held", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      go_to(40); check("loss.rel", 32'(o_aligner_rst_n), 32'd1);
      go_to(41); check_all("loss.relinked", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);

      // Fail escalation, ignored fail outside ALIGN, done beats same-cycle fail
      do_reset();
      i_gt_rx_rdy = 1'b1;
      go_to(12); i_align_fail = 1'b1;
      go_to(13); i_align_fail = 1'b0;
      go_to(15); i_align_fail = 1'b1;
      go_to(16); i_align_fail = 1'b0;
      check("esc.gt_early", 32'(o_gt_rx_reset), 32'd0);
      go_to(17); check_all("esc.gt_start", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      go_to(20); check("esc.gt_last", 32'(o_gt_rx_reset), 32'd1);
      go_to(21); check("esc.gt_end", 32'(o_gt_rx_reset), 32'd0);
      go_to(22); i_align_fail = 1'b1;
      go_to(23); i_align_fail = 1'b0;
      go_to(31); i_align_fail = 1'b1;
      go_to(32); i_align_fail = 1'b0;
      go_to(33); {i_align_done, i_align_fail} = 2'b11;
      go_to(34); i_align_fail = 1'b0;
      check_all("sim.pre", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      go_to(35); check_all("sim.linked", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      go_to(40); check("sim.no_gt", 32'(o_gt_rx_reset), 32'd0);

      // Timeout escalation twice, then budget exhausted, then restart
      do_reset();
      i_gt_rx_rdy = 1'b1;
      go_to(109); check("to1.gt_early", 32'(o_gt_rx_reset), 32'd0);
      go_to(110); check_all("to1.gt", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      go_to(113); check("to1.gt_last", 32'(o_gt_rx_reset), 32'd1);
      go_to(114); check("to1.gt_end", 32'(o_gt_rx_reset), 32'd0);
      go_to(222); check("to2.gt_early", 32'(o_gt_rx_reset), 32'd0);
      go_to(223); check_all("to2.gt", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
      go_to(335); check_all("to3.pre", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
      go_to(336); check_all("to3.failed", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      i_gt_rx_rdy = 1'b0;
      go_to(340); i_gt_rx_rdy = 1'b1;
      go_to(346); check_all("fail.hold", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      go_to(350); i_restart = 1'b1;
      go_to(351); i_restart = 1'b0;
      check("rst.pre", 32'(o_link_fail), 32'd1);
      go_to(352); check_all("rst.cleared", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // GT drop mid-ALIGN, timeout restarts, async reset during GT_RESET
      do_reset();
      i_gt_rx_rdy = 1'b1;
      go_to(59); i_gt_rx_rdy = 1'b0;
      go_to(60); check("drop.pre", 32'(o_aligner_rst_n), 32'd1);
      go_to(61); check_all("drop.rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      go_to(62); i_gt_rx_rdy = 1'b1;
      go_to(72); check("drop.realign", 32'(o_aligner_rst_n), 32'd1);
      go_to(171); check("drop.to_early", 32'(o_gt_rx_reset), 32'd0);
      go_to(172); check_all("drop.to_gt", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
      check_all("async.held", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
